// File: rtl/vlane_wb_arbiter.sv
// Writeback arbiter for one vector lane: EX results vs. buffered load returns on one RF write port.
// Optional macro VLANE_WB_BYPASS_EN lets a load skip the buffer when the lane is otherwise idle.
module vlane_wb_arbiter #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ex_valid,
  input  logic [DATA_WIDTH-1:0]        ex_data,
  input  logic [4:0]                   ex_dest,
  output logic                         ex_ready,
  input  logic                         ld_valid,
  input  logic [DATA_WIDTH-1:0]        ld_data,
  input  logic [4:0]                   ld_dest,
  output logic                         ld_ready,
  output logic                         wb_en,
  output logic [DATA_WIDTH-1:0]        wb_data,
  output logic [4:0]                   wb_dest,
  output logic                         wb_is_load,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [4:0]            dest_mem_q [FIFO_DEPTH];

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [StarveW-1:0]    starve_q, starve_d;

  logic                  wb_en_q, wb_en_d;
  logic                  wb_is_load_q, wb_is_load_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [4:0]            wb_dest_q, wb_dest_d;

  logic fifo_full, fifo_empty, starved;
  logic load_grant, bypass_grant, ex_grant;
  logic push, pop;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign starved    = (starve_q == StarveW'(STARVE_LIMIT));

  // Grant decode; everything is forced idle while rst is high.
  always_comb begin
    ld_ready     = ~rst & ~fifo_full;
    load_grant   = ~rst & ~fifo_empty & (~ex_valid | starved | fifo_full);
    bypass_grant = 1'b0;
`ifdef VLANE_WB_BYPASS_EN
    bypass_grant = ~rst & fifo_empty & ~ex_valid & ld_valid;
`endif
    ex_grant     = ~rst & ex_valid & ~load_grant;
    ex_ready     = ex_grant;
    push         = ld_valid & ld_ready & ~bypass_grant;
    pop          = load_grant;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
    if (fifo_empty || load_grant) begin
      starve_d = '0;
    end else if (ex_grant && !starved) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  // Data/dest hold their last value on idle cycles.
  always_comb begin
    wb_en_d      = load_grant | bypass_grant | ex_grant;
    wb_is_load_d = load_grant | bypass_grant;
    wb_data_d    = wb_data_q;
    wb_dest_d    = wb_dest_q;
    if (load_grant) begin
      wb_data_d = data_mem_q[rd_ptr_q];
      wb_dest_d = dest_mem_q[rd_ptr_q];
    end else if (bypass_grant) begin
      wb_data_d = ld_data;
      wb_dest_d = ld_dest;
    end else if (ex_grant) begin
      wb_data_d = ex_data;
      wb_dest_d = ex_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      wb_en_q      <= 1'b0;
      wb_is_load_q <= 1'b0;
      wb_data_q    <= '0;
      wb_dest_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      wb_en_q      <= wb_en_d;
      wb_is_load_q <= wb_is_load_d;
      wb_data_q    <= wb_data_d;
      wb_dest_q    <= wb_dest_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= ld_data;
      dest_mem_q[wr_ptr_q] <= ld_dest;
    end
  end

  assign wb_en      = wb_en_q;
  assign wb_is_load = wb_is_load_q;
  assign wb_data    = wb_data_q;
  assign wb_dest    = wb_dest_q;
  assign fifo_count = count_q;

`ifndef SYNTHESIS
  // A load offered while the buffer is full is lost; upstream must honour ld_ready.
  always_ff @(posedge clk) begin
    assert (rst || !ld_valid || ld_ready)
      else $error("vlane_wb_arbiter: ld_valid asserted while ld_ready=0, load dropped");
  end
`endif

endmodule

// File: tb/tb_vlane_wb_arbiter.sv
// Self-checking bench for vlane_wb_arbiter against a queue-based reference model.
// Honours VLANE_WB_BYPASS_EN when the same macro is defined for the build.
module tb_vlane_wb_arbiter;

  localparam int unsigned DataW  = 64;
  localparam int unsigned Depth  = 4;
  localparam int unsigned Limit  = 3;
`ifdef VLANE_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             ex_valid;
  logic [DataW-1:0] ex_data;
  logic [4:0]       ex_dest;
  logic             ex_ready;
  logic             ld_valid;
  logic [DataW-1:0] ld_data;
  logic [4:0]       ld_dest;
  logic             ld_ready;
  logic             wb_en;
  logic [DataW-1:0] wb_data;
  logic [4:0]       wb_dest;
  logic             wb_is_load;
  logic [2:0]       fifo_count;

  vlane_wb_arbiter #(
    .DATA_WIDTH  (DataW),
    .FIFO_DEPTH  (Depth),
    .STARVE_LIMIT(Limit)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_data   (ex_data),
    .ex_dest   (ex_dest),
    .ex_ready  (ex_ready),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_dest   (ld_dest),
    .ld_ready  (ld_ready),
    .wb_en     (wb_en),
    .wb_data   (wb_data),
    .wb_dest   (wb_dest),
    .wb_is_load(wb_is_load),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending loads in a queue, starvation as a plain integer.
  typedef struct {
    logic [4:0]       dest;
    logic [DataW-1:0] data;
  } ent_t;
  ent_t             mq[$];
  int               m_starve;
  bit               m_lg, m_bp, m_eg, m_ldr;
  logic             exp_wb_en, exp_wb_is_load;
  logic [DataW-1:0] exp_wb_data;
  logic [4:0]       exp_wb_dest;

  task automatic model_comb();
    if (rst) begin
      m_ldr = 0; m_lg = 0; m_bp = 0; m_eg = 0;
    end else begin
      m_ldr = (mq.size() < Depth);
      m_lg  = (mq.size() > 0) && (!ex_valid || m_starve >= Limit || mq.size() == Depth);
      m_bp  = Bypass && (mq.size() == 0) && !ex_valid && ld_valid;
      m_eg  = ex_valid && !m_lg;
    end
  endtask

  task automatic model_seq();
    bit   had_loads;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      exp_wb_en = 0; exp_wb_is_load = 0; exp_wb_data = '0; exp_wb_dest = '0;
      return;
    end
    had_loads = (mq.size() > 0);
    exp_wb_en = m_lg || m_bp || m_eg;
    exp_wb_is_load = m_lg || m_bp;
    if (m_lg) begin
      e = mq.pop_front();
      exp_wb_data = e.data; exp_wb_dest = e.dest;
    end else if (m_bp) begin
      exp_wb_data = ld_data; exp_wb_dest = ld_dest;
    end else if (m_eg) begin
      exp_wb_data = ex_data; exp_wb_dest = ex_dest;
    end
    if (ld_valid && m_ldr && !m_bp) begin
      e.dest = ld_dest; e.data = ld_data;
      mq.push_back(e);
    end
    if (!had_loads || m_lg) m_starve = 0;
    else if (m_eg && m_starve < Limit) m_starve++;
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic settle();
    #2;
    model_comb();
  endtask

  task automatic drain();
    int n;
    ex_valid = 0; ld_valid = 0;
    n = 0;
    while ((mq.size() != 0 || fifo_count != 0) && n < 20) begin
      tick();
      n++;
    end
    n_checks++;
    if (fifo_count !== 3'd0) begin
      $display("FAIL drain_timeout: fifo_count=%0d required=0", fifo_count);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1; ex_valid = 1; ex_data = 64'hDEAD_BEEF_0000_0001; ex_dest = 5'd7; ld_valid = 0;
    tick(); tick();
    settle();
    n_checks += 7;
    if (ex_ready !== 1'b0) begin $display("FAIL rst_ex_ready: got %0b want 0", ex_ready); n_fail++; end
    if (ld_ready !== 1'b0) begin $display("FAIL rst_ld_ready: got %0b want 0", ld_ready); n_fail++; end
    if (wb_en !== 1'b0) begin $display("FAIL rst_wb_en: got %0b want 0", wb_en); n_fail++; end
    if (wb_is_load !== 1'b0) begin $display("FAIL rst_wb_is_load: got %0b want 0", wb_is_load); n_fail++; end
    if (wb_data !== '0) begin $display("FAIL rst_wb_data: got %0h want 0", wb_data); n_fail++; end
    if (wb_dest !== 5'd0) begin $display("FAIL rst_wb_dest: got %0d want 0", wb_dest); n_fail++; end
    if (fifo_count !== 3'd0) begin $display("FAIL rst_count: got %0d want 0", fifo_count); n_fail++; end
    rst = 0; ex_valid = 0;
    tick();
    settle();
    n_checks++;
    if (ld_ready !== 1'b1) begin $display("FAIL post_rst_ld_ready: got %0b want 1", ld_ready); n_fail++; end
  endtask

  task automatic test_load_latency();
    int lat;
    drain();
    lat = Bypass ? 1 : 2;
    ex_valid = 0; ld_valid = 1; ld_dest = 5'd5; ld_data = 64'hA5;
    tick();
    ld_valid = 0;
    settle();
    n_checks++;
    if (wb_en !== Bypass) begin $display("FAIL lat_n1_wb_en: got %0b want %0b", wb_en, Bypass); n_fail++; end
    for (int c = 1; c < lat; c++) tick();
    settle();
    n_checks += 4;
    if (wb_en !== 1'b1) begin $display("FAIL lat_wb_en: got %0b want 1", wb_en); n_fail++; end
    if (wb_dest !== 5'd5) begin $display("FAIL lat_wb_dest: got %0d want 5", wb_dest); n_fail++; end
    if (wb_data !== 64'hA5) begin $display("FAIL lat_wb_data: got %0h want a5", wb_data); n_fail++; end
    if (wb_is_load !== 1'b1) begin $display("FAIL lat_is_load: got %0b want 1", wb_is_load); n_fail++; end
  endtask

  task automatic test_starvation();
    logic [DataW-1:0] ld_val, ex_val;
    drain();
    ld_val = {$urandom, $urandom};
    ex_valid = 1; ex_dest = 5'd3; ex_data = {$urandom, $urandom};
    ld_valid = 1; ld_dest = 5'd9; ld_data = ld_val;
    settle();
    n_checks++;
    if (ex_ready !== 1'b1) begin $display("FAIL starve_c0_ex_ready: got %0b want 1", ex_ready); n_fail++; end
    tick();
    ld_valid = 0;
    for (int c = 1; c <= 3; c++) begin
      ex_val = {$urandom, $urandom};
      ex_data = ex_val;
      settle();
      n_checks++;
      if (ex_ready !== 1'b1) begin
        $display("FAIL starve_c%0d_ex_ready: got %0b want 1", c, ex_ready); n_fail++;
      end
      tick();
      settle();
      n_checks++;
      if (wb_en !== 1'b1 || wb_is_load !== 1'b0 || wb_data !== ex_val) begin
        $display("FAIL starve_ex_wb_c%0d: en=%0b load=%0b data=%0h want en=1 load=0 data=%0h",
                 c, wb_en, wb_is_load, wb_data, ex_val);
        n_fail++;
      end
    end
    n_checks++;
    if (ex_ready !== 1'b0) begin $display("FAIL starve_c4_ex_ready: got %0b want 0", ex_ready); n_fail++; end
    tick();
    settle();
    n_checks++;
    if (wb_en !== 1'b1 || wb_is_load !== 1'b1 || wb_dest !== 5'd9 || wb_data !== ld_val) begin
      $display("FAIL starve_ld_wb: en=%0b load=%0b dest=%0d data=%0h want 1 1 9 %0h",
               wb_en, wb_is_load, wb_dest, wb_data, ld_val);
      n_fail++;
    end
    ex_valid = 0;
  endtask

  task automatic test_full();
    drain();
    ex_valid = 1; ex_dest = 5'd1;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_dest = 5'(i + 20); ld_data = {$urandom, $urandom};
      ex_data = {$urandom, $urandom};
      tick();
    end
    ld_valid = 0;
    settle();
    n_checks += 3;
    if (fifo_count !== 3'd4) begin $display("FAIL full_count: got %0d want 4", fifo_count); n_fail++; end
    if (ld_ready !== 1'b0) begin $display("FAIL full_ld_ready: got %0b want 0", ld_ready); n_fail++; end
    if (ex_ready !== 1'b0) begin $display("FAIL full_ex_ready: got %0b want 0", ex_ready); n_fail++; end
    tick();
    settle();
    n_checks += 3;
    if (ld_ready !== 1'b1) begin $display("FAIL full_next_ld_ready: got %0b want 1", ld_ready); n_fail++; end
    if (fifo_count !== 3'd3) begin $display("FAIL full_next_count: got %0d want 3", fifo_count); n_fail++; end
    if (wb_is_load !== 1'b1 || wb_dest !== 5'd20) begin
      $display("FAIL full_head_wb: load=%0b dest=%0d want load=1 dest=20", wb_is_load, wb_dest);
      n_fail++;
    end
    ex_valid = 0;
  endtask

  task automatic test_push_pop_order();
    logic [4:0]       iss_dest[$];
    logic [DataW-1:0] iss_data[$];
    logic [4:0]       got_dest[$];
    logic [DataW-1:0] got_data[$];
    int issued, cyc;
    drain();
    ex_valid = 1; ex_dest = 5'd2;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1; ld_dest = 5'(i + 10); ld_data = {$urandom, $urandom};
      iss_dest.push_back(ld_dest); iss_data.push_back(ld_data);
      tick();
    end
    ex_valid = 0; ld_valid = 1; ld_dest = 5'd12; ld_data = {$urandom, $urandom};
    iss_dest.push_back(ld_dest); iss_data.push_back(ld_data);
    settle();
    n_checks++;
    if (fifo_count !== 3'd2) begin $display("FAIL pp_pre_count: got %0d want 2", fifo_count); n_fail++; end
    tick();
    ld_valid = 0;
    settle();
    n_checks++;
    if (fifo_count !== 3'd2) begin $display("FAIL pp_count: got %0d want 2", fifo_count); n_fail++; end
    if (wb_en && wb_is_load) begin got_dest.push_back(wb_dest); got_data.push_back(wb_data); end
    issued = 0; cyc = 0;
    while ((issued < 10 || fifo_count != 0 || mq.size() != 0) && cyc < 200) begin
      ex_valid = ($urandom_range(0, 99) < 50);
      ex_data = {$urandom, $urandom};
      model_comb();
      ld_valid = (issued < 10) && m_ldr && ($urandom_range(0, 99) < 70);
      if (ld_valid) begin
        ld_dest = 5'($urandom); ld_data = {$urandom, $urandom};
        iss_dest.push_back(ld_dest); iss_data.push_back(ld_data);
        issued++;
      end
      tick();
      settle();
      if (wb_en && wb_is_load) begin got_dest.push_back(wb_dest); got_data.push_back(wb_data); end
      cyc++;
    end
    ex_valid = 0; ld_valid = 0;
    tick();
    settle();
    if (wb_en && wb_is_load) begin got_dest.push_back(wb_dest); got_data.push_back(wb_data); end
    n_checks++;
    if (got_dest.size() != iss_dest.size()) begin
      $display("FAIL order_len: got %0d writes want %0d", got_dest.size(), iss_dest.size());
      n_fail++;
    end
    for (int i = 0; i < iss_dest.size() && i < got_dest.size(); i++) begin
      n_checks++;
      if (got_dest[i] !== iss_dest[i] || got_data[i] !== iss_data[i]) begin
        $display("FAIL order_%0d: got dest=%0d data=%0h want dest=%0d data=%0h",
                 i, got_dest[i], got_data[i], iss_dest[i], iss_data[i]);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid();
    drain();
    ex_valid = 1; ex_dest = 5'd4;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_dest = 5'(i + 28); ld_data = {$urandom, $urandom};
      ex_data = {$urandom, $urandom};
      tick();
    end
    ld_valid = 0;
    settle();
    n_checks += 2;
    if (fifo_count !== 3'd3) begin $display("FAIL mid_pre_count: got %0d want 3", fifo_count); n_fail++; end
    if (wb_en !== 1'b1) begin $display("FAIL mid_pre_wb_en: got %0b want 1", wb_en); n_fail++; end
    rst = 1;
    settle();
    n_checks += 2;
    if (ex_ready !== 1'b0) begin $display("FAIL mid_rst_ex_ready: got %0b want 0", ex_ready); n_fail++; end
    if (ld_ready !== 1'b0) begin $display("FAIL mid_rst_ld_ready: got %0b want 0", ld_ready); n_fail++; end
    tick();
    rst = 0; ex_valid = 0;
    settle();
    n_checks += 2;
    if (wb_en !== 1'b0) begin $display("FAIL mid_wb_en: got %0b want 0", wb_en); n_fail++; end
    if (fifo_count !== 3'd0) begin $display("FAIL mid_count: got %0d want 0", fifo_count); n_fail++; end
    for (int c = 0; c < 6; c++) begin
      tick();
      settle();
      n_checks++;
      if (wb_en !== 1'b0) begin $display("FAIL mid_ghost_c%0d: wb_en=%0b want 0", c, wb_en); n_fail++; end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      ex_valid = ($urandom_range(0, 99) < 60);
      ex_data = {$urandom, $urandom}; ex_dest = 5'($urandom);
      ld_valid = 0;
      model_comb();
      ld_valid = !rst && m_ldr && ($urandom_range(0, 99) < 55);
      ld_data = {$urandom, $urandom}; ld_dest = 5'($urandom);
      settle();
      n_checks++;
      if (ex_ready !== m_eg || ld_ready !== m_ldr || fifo_count !== 3'(mq.size())) begin
        $display("FAIL rnd_comb_c%0d: ex_ready=%0b ld_ready=%0b count=%0d want %0b %0b %0d",
                 c, ex_ready, ld_ready, fifo_count, m_eg, m_ldr, mq.size());
        n_fail++;
      end
      n_checks++;
      if (wb_en !== exp_wb_en || wb_is_load !== exp_wb_is_load || wb_data !== exp_wb_data ||
          wb_dest !== exp_wb_dest) begin
        $display("FAIL rnd_wb_c%0d: en=%0b load=%0b dest=%0d data=%0h want %0b %0b %0d %0h",
                 c, wb_en, wb_is_load, wb_dest, wb_data,
                 exp_wb_en, exp_wb_is_load, exp_wb_dest, exp_wb_data);
        n_fail++;
      end
      tick();
    end
    rst = 0; ex_valid = 0; ld_valid = 0;
  endtask

  initial begin
    rst = 1; ex_valid = 0; ex_data = '0; ex_dest = '0;
    ld_valid = 0; ld_data = '0; ld_dest = '0;
    m_starve = 0;
    exp_wb_en = 0; exp_wb_is_load = 0; exp_wb_data = '0; exp_wb_dest = '0;
    tick();
    test_reset();
    test_load_latency();
    test_starvation();
    test_full();
    test_push_pop_order();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
